// File: rtl/rv32i_multicycle_core_pkg.sv
// rtl/rv32i_multicycle_core_pkg.sv - shared constants, enums and decode helpers for the multi-cycle RV32I core
package rv32i_multicycle_core_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic MM_ENB_W = 1'b1;
    localparam logic MM_ENB_R = 1'b0;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_WRITEBACK
    } state_t;

    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] decode_imm(input logic [31:0] ir);
        case (ir[6:0])
            OPC_STORE:          return {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OPC_BRANCH:         return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: return {ir[31:12], 12'b0};
            OPC_JAL:            return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:            return {{20{ir[31]}}, ir[31:20]};
        endcase
    endfunction

    // Memory returns zero-extended data; only the signed loads need widening here.
    function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [2:0] f3);
        case (f3)
            F3_LB:   return {{24{d[7]}}, d[7:0]};
            F3_LH:   return {{16{d[15]}}, d[15:0]};
            F3_LBU:  return {24'b0, d[7:0]};
            F3_LHU:  return {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_multicycle_core_alu.sv
// rtl/rv32i_multicycle_core_alu.sv - combinational RV32I ALU with zero flag used for branch compares
module rv32_alu
    import rv32i_multicycle_core_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        cmp_zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    assign cmp_zero = (result == '0);

endmodule

// File: rtl/rv32i_multicycle_core.sv
// rtl/rv32i_multicycle_core.sv - multi-cycle non-pipelined RV32I core (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK)
module rv32i_multicycle_core
    import rv32i_multicycle_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0800,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     cnt,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] dataI,
    output logic [XLEN-1:0] dataO,
    output logic            store_or_load,
    output logic [1:0]      width_of_data,
    output logic [XLEN-1:0] locat_of_data,
    output logic [XLEN-1:0] where_is_instr
);

    state_t          state, state_n;
    logic [XLEN-1:0] pc, ir, a, b, imm, alu_out, mdr;
    logic [XLEN-1:0] rf [32];
    logic [XLEN-1:0] alu_a, alu_b, alu_res, wb_data;
    alu_op_t         alu_op;
    logic            cmp_zero, br_taken, writes_rd;
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic            unused_cnt;

    assign unused_cnt     = ^cnt;
    assign where_is_instr = pc;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];

    // Branches reuse SUB (equality) and SLT/SLTU; funct3[0] inverts the sense.
    assign br_taken  = (f3[2] ? ~cmp_zero : cmp_zero) ^ f3[0];
    assign writes_rd = (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL) ||
                       (opcode == OPC_JALR) || (opcode == OPC_LOAD) || (opcode == OPC_OP_IMM) ||
                       (opcode == OPC_OP);
    assign wb_data   = (opcode == OPC_JAL || opcode == OPC_JALR) ? pc + 32'd4 :
                       (opcode == OPC_LOAD) ? mdr : alu_out;

    rv32_alu u_alu (
        .op       (alu_op),
        .a        (alu_a),
        .b        (alu_b),
        .result   (alu_res),
        .cmp_zero (cmp_zero)
    );

    always_comb begin
        state_n       = state;
        alu_a         = a;
        alu_b         = imm;
        alu_op        = ALU_ADD;
        store_or_load = MM_ENB_R;
        width_of_data = SZ_WORD;
        locat_of_data = '0;
        dataO         = '0;
        case (opcode)
            OPC_OP:     begin alu_b = b; alu_op = alu_from_f3(f3, ir[30]); end
            OPC_OP_IMM: alu_op = alu_from_f3(f3, (f3 == F3_SR) && ir[30]);
            OPC_BRANCH: begin
                alu_b  = b;
                alu_op = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            end
            OPC_LUI:             alu_a = '0;
            OPC_AUIPC, OPC_JAL:  alu_a = pc;
            default: ;
        endcase
        case (state)
            ST_FETCH:  state_n = ST_DECODE;
            ST_DECODE: state_n = ST_EXECUTE;
            ST_EXECUTE: begin
                if (opcode == OPC_BRANCH)
                    state_n = ST_FETCH;
                else if (opcode == OPC_LOAD || opcode == OPC_STORE)
                    state_n = ST_MEMORY;
                else
                    state_n = ST_WRITEBACK;
            end
            ST_MEMORY: state_n = (opcode == OPC_STORE) ? ST_FETCH : ST_WRITEBACK;
            ST_WRITEBACK: state_n = ST_FETCH;
            default: state_n = ST_FETCH;
        endcase
        if ((state == ST_EXECUTE || state == ST_MEMORY) &&
            (opcode == OPC_LOAD || opcode == OPC_STORE)) begin
            locat_of_data = (state == ST_EXECUTE) ? alu_res : alu_out;
            width_of_data = f3[1:0];
            if (opcode == OPC_STORE) begin
                case (f3[1:0])
                    SZ_BYTE: dataO = {24'b0, b[7:0]};
                    SZ_HALF: dataO = {16'b0, b[15:0]};
                    default: dataO = b;
                endcase
                store_or_load = (state == ST_MEMORY) ? MM_ENB_W : MM_ENB_R;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            imm     <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            state <= state_n;
            case (state)
                ST_FETCH: ir <= instr;
                ST_DECODE: begin
                    a   <= rf[rs1];
                    b   <= rf[rs2];
                    imm <= decode_imm(ir);
                end
                ST_EXECUTE: begin
                    alu_out <= alu_res;
                    if (opcode == OPC_BRANCH)
                        pc <= br_taken ? pc + imm : pc + 32'd4;
                end
                ST_MEMORY: begin
                    if (opcode == OPC_STORE)
                        pc <= pc + 32'd4;
                    else
                        mdr <= load_ext(dataI, f3);
                end
                ST_WRITEBACK: begin
                    if (writes_rd && rd != 5'd0)
                        rf[rd] <= wb_data;
                    if (opcode == OPC_JAL)
                        pc <= alu_out;
                    else if (opcode == OPC_JALR)
                        pc <= alu_out & ~32'd1;
                    else
                        pc <= pc + 32'd4;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// tb/tb_rv32i_multicycle_core.sv - self-checking bench: directed and random programs against an ISA-level model
module tb_rv32i_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cnt = '0;
    logic [31:0] instr, dataI, dataO, locat_of_data, where_is_instr;
    logic        store_or_load;
    logic [1:0]  width_of_data;

    logic [31:0] ram [0:1023];
    logic [31:0] rd_word;

    logic [7:0]  ref_mem [0:4095];
    logic [31:0] ref_x [0:31];
    logic [31:0] ref_pc;

    int total = 0;
    int bad   = 0;

    rv32i_multicycle_core dut (
        .clk            (clk),
        .rst            (rst),
        .cnt            (cnt),
        .instr          (instr),
        .dataI          (dataI),
        .dataO          (dataO),
        .store_or_load  (store_or_load),
        .width_of_data  (width_of_data),
        .locat_of_data  (locat_of_data),
        .where_is_instr (where_is_instr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 32'd1;

    assign instr = ram[where_is_instr[11:2]];

    always_comb begin
        rd_word = ram[locat_of_data[11:2]];
        case (width_of_data)
            2'b00:   dataI = (rd_word >> {locat_of_data[1:0], 3'b000}) & 32'h0000_00FF;
            2'b01:   dataI = (rd_word >> {locat_of_data[1], 4'b0000}) & 32'h0000_FFFF;
            default: dataI = rd_word;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sz_mask(input logic [1:0] w);
        return (w == 2'b00) ? 32'h0000_00FF : (w == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input bit alt,
                                            input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx;
        sx = x;
        case (f3)
            3'd0: return alt ? x - y : x + y;
            3'd1: return x << y[4:0];
            3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return alt ? 32'(sx >>> y[4:0]) : x >> y[4:0];
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    // Executes the instruction at ref_pc, returning its cycle cost and any memory write.
    task automatic ref_step(output int cyc, output bit st, output logic [31:0] sa,
                            output logic [1:0] sw, output logic [31:0] sd);
        logic [31:0] ins, v1, v2, iI, iS, iB, iJ, res, ad, npc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        bit          wr, tk;
        int          p;
        p   = int'(ref_pc[11:0]);
        ins = {ref_mem[p+3], ref_mem[p+2], ref_mem[p+1], ref_mem[p]};
        rd  = ins[11:7];
        f3  = ins[14:12];
        v1  = ref_x[ins[19:15]];
        v2  = ref_x[ins[24:20]];
        iI  = {{20{ins[31]}}, ins[31:20]};
        iS  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        iB  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iJ  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        cyc = 4; st = 0; sa = '0; sw = '0; sd = '0; wr = 0; res = '0; tk = 0;
        npc = ref_pc + 32'd4;
        case (ins[6:0])
            7'h37: begin wr = 1; res = {ins[31:12], 12'b0}; end
            7'h17: begin wr = 1; res = ref_pc + {ins[31:12], 12'b0}; end
            7'h6F: begin wr = 1; res = ref_pc + 32'd4; npc = ref_pc + iJ; end
            7'h67: begin wr = 1; res = ref_pc + 32'd4; npc = (v1 + iI) & ~32'd1; end
            7'h63: begin
                cyc = 3;
                case (f3)
                    3'd0: tk = (v1 == v2);
                    3'd1: tk = (v1 != v2);
                    3'd4: tk = ($signed(v1) < $signed(v2));
                    3'd5: tk = ($signed(v1) >= $signed(v2));
                    3'd6: tk = (v1 < v2);
                    3'd7: tk = (v1 >= v2);
                    default: tk = 0;
                endcase
                if (tk) npc = ref_pc + iB;
            end
            7'h03: begin
                cyc = 5; wr = 1; ad = v1 + iI;
                case (f3)
                    3'd0: res = 32'($signed(ref_mem[ad[11:0]]));
                    3'd4: res = {24'b0, ref_mem[ad[11:0]]};
                    3'd1: res = 32'($signed({ref_mem[ad[11:0] + 12'd1], ref_mem[ad[11:0]]}));
                    3'd5: res = {16'b0, ref_mem[ad[11:0] + 12'd1], ref_mem[ad[11:0]]};
                    default: res = {ref_mem[ad[11:0] + 12'd3], ref_mem[ad[11:0] + 12'd2],
                                    ref_mem[ad[11:0] + 12'd1], ref_mem[ad[11:0]]};
                endcase
            end
            7'h23: begin
                st = 1; ad = v1 + iS; sa = ad; sw = f3[1:0]; sd = v2 & sz_mask(f3[1:0]);
                for (int k = 0; k < 4; k++)
                    if (k == 0 || (k == 1 && f3[1:0] != 2'b00) || f3[1:0] == 2'b10)
                        ref_mem[ad[11:0] + 12'(k)] = v2[8*k +: 8];
            end
            7'h13: begin wr = 1; res = alu_ref(f3, ins[30] && f3 == 3'd5, v1, iI); end
            7'h33: begin wr = 1; res = alu_ref(f3, ins[30], v1, v2); end
            default: ;
        endcase
        if (wr && rd != 5'd0) ref_x[rd] = res;
        ref_pc = npc;
    endtask

    function automatic logic [31:0] rand_instr(input int i, input int n);
        int          sel, k, kmax;
        logic [2:0]  f3;
        logic [4:0]  rd, r1, r2, sh;
        logic [11:0] ad;
        kmax = (n - i < 3) ? n - i : 3;
        k    = int'($urandom_range(1, kmax));
        sel  = int'($urandom_range(0, 99));
        f3   = 3'($urandom_range(0, 7));
        rd   = 5'($urandom_range(0, 31));
        r1   = 5'($urandom_range(0, 31));
        r2   = 5'($urandom_range(0, 31));
        sh   = 5'($urandom_range(0, 31));
        if (sel < 25) begin
            if (f3 == 3'd1)      return enc_i(7'h13, f3, rd, r1, {7'b0, sh});
            else if (f3 == 3'd5) return enc_i(7'h13, f3, rd, r1, {1'b0, 1'($urandom_range(0, 1)), 5'b0, sh});
            else                 return enc_i(7'h13, f3, rd, r1, 12'($urandom));
        end else if (sel < 50) begin
            return enc_r((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00, f3, rd, r1, r2);
        end else if (sel < 58) begin
            return {20'($urandom), rd, $urandom_range(0, 1) == 1 ? 7'h37 : 7'h17};
        end else if (sel < 70) begin
            case ($urandom_range(0, 4))
                0: f3 = 3'd0; 1: f3 = 3'd4; 2: f3 = 3'd1; 3: f3 = 3'd5; default: f3 = 3'd2;
            endcase
            ad = 12'(32'h100 + 4 * $urandom_range(0, 191));
            if (f3[1:0] == 2'b00) ad = ad + 12'($urandom_range(0, 3));
            if (f3[1:0] == 2'b01) ad = ad + 12'(2 * $urandom_range(0, 1));
            return enc_i(7'h03, f3, rd, 5'd0, ad);
        end else if (sel < 80) begin
            f3 = 3'($urandom_range(0, 2));
            ad = 12'(32'h100 + 4 * $urandom_range(0, 191));
            if (f3 == 3'd0) ad = ad + 12'($urandom_range(0, 3));
            if (f3 == 3'd1) ad = ad + 12'(2 * $urandom_range(0, 1));
            return enc_s(f3, 5'd0, r2, ad);
        end else if (sel < 90) begin
            case ($urandom_range(0, 5))
                0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd4; 3: f3 = 3'd5; 4: f3 = 3'd6; default: f3 = 3'd7;
            endcase
            if ($urandom_range(0, 3) == 0) r2 = r1;
            return enc_b(f3, r1, r2, 13'(4 * k));
        end else if (sel < 95) begin
            return enc_j(rd, 21'(4 * k));
        end else begin
            case ($urandom_range(0, 3))
                0: return 32'h0000_000F;
                1: return 32'h0000_0073;
                2: return 32'h0010_0073;
                default: return {25'($urandom), 7'b1111011};
            endcase
        end
    endfunction

    task automatic load_prog(input logic [31:0] p[$]);
        for (int w = 0; w < 1024; w++) ram[w] = $urandom;
        foreach (p[i]) ram[10'h200 + 10'(i)] = p[i];
        ram[0] = 32'h0000_006F;
    endtask

    task automatic sync_ref();
        for (int w = 0; w < 1024; w++)
            for (int k = 0; k < 4; k++) ref_mem[4*w + k] = ram[w][8*k +: 8];
    endtask

    task automatic run_prog();
        int          cyc, n, nst;
        bit          st;
        logic [31:0] sa, sd, cur;
        logic [1:0]  sw;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_pc", where_is_instr, 32'h800);
            chk("rst_sol", {31'b0, store_or_load}, 32'd0);
        end
        chk("rst_width", {30'b0, width_of_data}, 32'd2);
        chk("rst_locat", locat_of_data, 32'd0);
        chk("rst_dataO", dataO, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) ref_x[i] = '0;
        ref_pc = 32'h800;
        for (int k = 0; k < 300 && ref_pc != 32'd0; k++) begin
            cur = ref_pc;
            ref_step(cyc, st, sa, sw, sd);
            n = 0; nst = 0;
            do begin
                @(negedge clk);
                n++;
                if (store_or_load) begin
                    nst++;
                    chk("st_addr", locat_of_data, sa);
                    chk("st_width", {30'b0, width_of_data}, {30'b0, sw});
                    chk("st_data", dataO & sz_mask(sw), sd);
                    case (width_of_data)
                        2'b00:   ram[locat_of_data[11:2]][8*locat_of_data[1:0] +: 8] = dataO[7:0];
                        2'b01:   ram[locat_of_data[11:2]][16*locat_of_data[1] +: 16] = dataO[15:0];
                        default: ram[locat_of_data[11:2]] = dataO;
                    endcase
                end
            end while (where_is_instr == cur && n < 12);
            chk("cycles", 32'(n), 32'(cyc));
            chk("stores", 32'(nst), {31'b0, st});
            chk("next_pc", where_is_instr, ref_pc);
            if (where_is_instr !== ref_pc) break;
        end
        chk("terminated", where_is_instr, 32'd0);
        for (int i = 0; i < 32; i++) chk($sformatf("x%0d", i), dut.rf[i], ref_x[i]);
        for (int w = 32'h40; w < 32'h100; w++)
            chk($sformatf("mem%0h", 4*w), ram[w],
                {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
    endtask

    initial begin
        logic [31:0] prog[$];
        prog = '{
            enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5),        // 800 ADDI x1,x0,5
            enc_r(7'h00, 3'd0, 5'd2, 5'd1, 5'd1),         // 804 ADD x2,x1,x1
            enc_s(3'd2, 5'd0, 5'd2, 12'h100),             // 808 SW x2,0x100(x0)
            enc_i(7'h03, 3'd0, 5'd3, 5'd0, 12'h104),      // 80C LB x3
            enc_i(7'h03, 3'd4, 5'd4, 5'd0, 12'h104),      // 810 LBU x4
            enc_b(3'd0, 5'd0, 5'd0, 13'd8),               // 814 BEQ -> 81C
            enc_i(7'h13, 3'd0, 5'd9, 5'd0, 12'd1),        // 818 skipped
            enc_b(3'd1, 5'd0, 5'd0, 13'd8),               // 81C BNE not taken
            enc_j(5'd1, 21'd8),                           // 820 JAL x1,+8
            enc_i(7'h13, 3'd0, 5'd9, 5'd0, 12'd2),        // 824 skipped
            enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd7),        // 828 ADDI x0,x0,7
            {20'd0, 5'd6, 7'h17},                         // 82C AUIPC x6,0
            enc_i(7'h67, 3'd0, 5'd7, 5'd6, 12'd13),       // 830 JALR x7,13(x6)
            enc_i(7'h13, 3'd0, 5'd9, 5'd0, 12'd3),        // 834 skipped
            enc_i(7'h67, 3'd0, 5'd0, 5'd5, 12'd0)         // 838 JALR x0,0(x5)
        };
        load_prog(prog);
        ram[32'h41] = 32'h0000_0080;
        sync_ref();

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_x1", dut.rf[1], 32'd0);
        chk("abort_pc", where_is_instr, 32'h800);

        run_prog();
        chk("dir_x2", dut.rf[2], 32'd10);
        chk("dir_mem100", ram[32'h40], 32'd10);
        chk("dir_lb", dut.rf[3], 32'hFFFF_FF80);
        chk("dir_lbu", dut.rf[4], 32'h0000_0080);
        chk("dir_jal_link", dut.rf[1], 32'h824);
        chk("dir_jalr_link", dut.rf[7], 32'h834);
        chk("dir_skipped", dut.rf[9], 32'd0);
        chk("dir_x0", dut.rf[0], 32'd0);

        for (int r = 0; r < 8; r++) begin
            prog.delete();
            for (int i = 0; i < 40; i++) prog.push_back(rand_instr(i, 40));
            prog.push_back(enc_i(7'h67, 3'd0, 5'd0, 5'd0, 12'd0));
            load_prog(prog);
            sync_ref();
            run_prog();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
